// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the operand read stage: source-select codes and
// default register index / data widths.
package cpu_defs;

    localparam logic [1:0] SEL_RS   = 2'b00;
    localparam logic [1:0] SEL_RT   = 2'b01;
    localparam logic [1:0] SEL_RD   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/operand_bypass.sv
// One operand port: register-index select, EX/MEM forwarding and the
// per-port hazard bit. Purely combinational.
module operand_bypass
    import cpu_defs::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic [1:0]    sel,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic [AW-1:0] rd,
    input  logic          ex_wen,
    input  logic          ex_is_load,
    input  logic [AW-1:0] ex_waddr,
    input  logic [DW-1:0] ex_wdata,
    input  logic          mem_wen,
    input  logic          mem_data_ok,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] rf_rdata,
    output logic [AW-1:0] idx,
    output logic [DW-1:0] value,
    output logic          hazard
);

    logic nonzero;
    logic ex_match;
    logic ex_alu_hit;
    logic mem_match;
    logic mem_hit;

    always_comb begin
        idx = '0;
        case (sel)
            SEL_RS:  idx = rs;
            SEL_RT:  idx = rt;
            SEL_RD:  idx = rd;
            default: idx = '0;
        endcase
    end

    assign nonzero    = (idx != '0);
    assign ex_match   = ex_wen && (ex_waddr == idx);
    assign ex_alu_hit = ex_match && !ex_is_load;
    assign mem_match  = mem_wen && (mem_waddr == idx);
    assign mem_hit    = mem_match && mem_data_ok;

    // Register 0 reads as zero and is never forwarded or stalled on.
    always_comb begin
        value = rf_rdata;
        if (!nonzero)
            value = '0;
        else if (ex_alu_hit)
            value = ex_wdata;
        else if (mem_hit)
            value = mem_wdata;
    end

    assign hazard = nonzero &&
                    ((ex_match && ex_is_load) ||
                     (mem_match && !mem_data_ok && !ex_alu_hit));

endmodule

// File: rtl/reg_read_stage.sv
// Decode-to-execute operand stage: NUM_RD forwarded read ports feeding a
// valid/ready ID/EX register with load-use stall and a saturating stall count.
module reg_read_stage
    import cpu_defs::*;
#(
    parameter int NUM_RD = 2,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [AW-1:0]        rs_id,
    input  logic [AW-1:0]        rt_id,
    input  logic [AW-1:0]        rd_id,
    input  logic [2*NUM_RD-1:0]  sel_id,
    output logic [AW*NUM_RD-1:0] rf_raddr,
    input  logic [DW*NUM_RD-1:0] rf_rdata,
    input  logic                 ex_wen,
    input  logic                 ex_is_load,
    input  logic [AW-1:0]        ex_waddr,
    input  logic [DW-1:0]        ex_wdata,
    input  logic                 mem_wen,
    input  logic                 mem_data_ok,
    input  logic [AW-1:0]        mem_waddr,
    input  logic [DW-1:0]        mem_wdata,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [AW*NUM_RD-1:0] ex_raddr,
    output logic [DW*NUM_RD-1:0] ex_op,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic [DW*NUM_RD-1:0] port_val;
    logic [NUM_RD-1:0]    port_haz;
    logic                 hazard;
    logic                 accept;

    logic                 ex_valid_q,  ex_valid_d;
    logic [AW*NUM_RD-1:0] ex_raddr_q,  ex_raddr_d;
    logic [DW*NUM_RD-1:0] ex_op_q,     ex_op_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        operand_bypass #(.AW(AW), .DW(DW)) u_bypass (
            .sel         (sel_id[2*p +: 2]),
            .rs          (rs_id),
            .rt          (rt_id),
            .rd          (rd_id),
            .ex_wen      (ex_wen),
            .ex_is_load  (ex_is_load),
            .ex_waddr    (ex_waddr),
            .ex_wdata    (ex_wdata),
            .mem_wen     (mem_wen),
            .mem_data_ok (mem_data_ok),
            .mem_waddr   (mem_waddr),
            .mem_wdata   (mem_wdata),
            .rf_rdata    (rf_rdata[DW*p +: DW]),
            .idx         (rf_raddr[AW*p +: AW]),
            .value       (port_val[DW*p +: DW]),
            .hazard      (port_haz[p])
        );
    end

    assign hazard   = id_valid && (|port_haz);
    assign id_ready = !hazard && (!ex_valid_q || ex_ready);
    assign accept   = id_valid && id_ready;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_raddr_d  = ex_raddr_q;
        ex_op_d     = ex_op_q;
        stall_cnt_d = stall_cnt_q;

        if (hazard && !flush && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        // A hazard forces !accept, so the bubble comes from the drain branch.
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            ex_raddr_d = rf_raddr;
            ex_op_d    = port_val;
        end else if (ex_ready || !ex_valid_q) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ex_valid_q  <= 1'b0;
            ex_raddr_q  <= '0;
            ex_op_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_raddr_q  <= ex_raddr_d;
            ex_op_q     <= ex_op_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_raddr  = ex_raddr_q;
    assign ex_op     = ex_op_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the stage.
module tb_reg_read_stage;

    localparam int NUM_RD = 2;
    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 3;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 id_valid;
    logic                 id_ready;
    logic [AW-1:0]        rs_id, rt_id, rd_id;
    logic [2*NUM_RD-1:0]  sel_id;
    logic [AW*NUM_RD-1:0] rf_raddr;
    logic [DW*NUM_RD-1:0] rf_rdata;
    logic                 ex_wen, ex_is_load;
    logic [AW-1:0]        ex_waddr;
    logic [DW-1:0]        ex_wdata;
    logic                 mem_wen, mem_data_ok;
    logic [AW-1:0]        mem_waddr;
    logic [DW-1:0]        mem_wdata;
    logic                 flush;
    logic                 ex_ready;
    logic                 ex_valid;
    logic [AW*NUM_RD-1:0] ex_raddr;
    logic [DW*NUM_RD-1:0] ex_op;
    logic [CNT_W-1:0]     stall_cnt;

    logic                 s_id_ready, s_ex_valid;
    logic [AW*NUM_RD-1:0] s_rf_raddr, s_ex_raddr;
    logic [DW*NUM_RD-1:0] s_ex_op;
    logic [SAT_W-1:0]     s_stall_cnt;

    always #5 clk = ~clk;

    reg_read_stage #(.NUM_RD(NUM_RD), .AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_ready(id_ready),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .sel_id(sel_id),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_wen(mem_wen), .mem_data_ok(mem_data_ok), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_raddr(ex_raddr), .ex_op(ex_op), .stall_cnt(stall_cnt)
    );

    reg_read_stage #(.NUM_RD(NUM_RD), .AW(AW), .DW(DW), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_ready(s_id_ready),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .sel_id(sel_id),
        .rf_raddr(s_rf_raddr), .rf_rdata(rf_rdata),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_wen(mem_wen), .mem_data_ok(mem_data_ok), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(s_ex_valid),
        .ex_raddr(s_ex_raddr), .ex_op(s_ex_op), .stall_cnt(s_stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic                 m_valid;
    logic [DW*NUM_RD-1:0] m_op;
    logic [AW*NUM_RD-1:0] m_raddr;
    int                   m_cnt;
    bit                   m_known = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] m_idx(input int p);
        int s;
        s = int'(sel_id[2*p +: 2]);
        if (s == 0) return rs_id;
        if (s == 1) return rt_id;
        if (s == 2) return rd_id;
        return '0;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Applies the current inputs for one clock and checks comb and registered outputs.
    task automatic step();
        logic [AW-1:0]        idx;
        logic [DW-1:0]        val;
        logic [DW*NUM_RD-1:0] nv;
        logic [AW*NUM_RD-1:0] na;
        bit                   any_haz, haz, rdy, ex_fwd, mem_fwd;
        any_haz = 0;
        nv = '0;
        na = '0;
        #1;
        for (int p = 0; p < NUM_RD; p++) begin
            idx     = m_idx(p);
            ex_fwd  = ex_wen && (ex_waddr == idx) && !ex_is_load;
            mem_fwd = mem_wen && (mem_waddr == idx) && mem_data_ok;
            if (idx == 0)    val = '0;
            else if (ex_fwd) val = ex_wdata;
            else if (mem_fwd) val = mem_wdata;
            else             val = rf_rdata[p*DW +: DW];
            if (idx != 0 && ex_wen && ex_waddr == idx && ex_is_load) any_haz = 1;
            if (idx != 0 && mem_wen && mem_waddr == idx && !mem_data_ok && !ex_fwd) any_haz = 1;
            na[p*AW +: AW] = idx;
            nv[p*DW +: DW] = val;
        end
        haz = id_valid && any_haz;
        rdy = !haz && (!m_valid || ex_ready);
        if (m_known) check("id_ready", id_ready, rdy);
        check("rf_raddr", rf_raddr, na);

        if (!resetn) begin
            m_valid = 0; m_op = '0; m_raddr = '0; m_cnt = 0;
        end else begin
            if (haz && !flush) m_cnt++;
            if (flush) m_valid = 0;
            else if (id_valid && rdy) begin
                m_valid = 1; m_op = nv; m_raddr = na;
            end else if (ex_ready || !m_valid) m_valid = 0;
        end

        @(posedge clk);
        #1;
        if (!resetn) m_known = 1'b1;
        if (m_known) begin
            check("ex_valid", ex_valid, m_valid);
            check("ex_op", ex_op, m_op);
            check("ex_raddr", ex_raddr, m_raddr);
            check("stall_cnt", stall_cnt, min_int(m_cnt, 65535));
            check("stall_cnt_sat", s_stall_cnt, min_int(m_cnt, 7));
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_valid = 0; rs_id = '0; rt_id = '0; rd_id = '0; sel_id = '0;
        rf_rdata = '0; ex_wen = 0; ex_is_load = 0; ex_waddr = '0; ex_wdata = '0;
        mem_wen = 0; mem_data_ok = 0; mem_waddr = '0; mem_wdata = '0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic set_load_hazard();
        sel_id = 4'b1100; rs_id = 5'd3;
        ex_wen = 1; ex_is_load = 1; ex_waddr = 5'd3; ex_wdata = 32'h1234;
        mem_wen = 0; id_valid = 1; ex_ready = 1;
    endtask

    logic [DW*NUM_RD-1:0] held_op;

    initial begin
        clear_inputs();
        resetn = 0;
        id_valid = 1;
        @(negedge clk);

        // reset held two cycles with a pending instruction
        step();
        step();
        check("rst_ex_valid", ex_valid, 1'b0);
        check("rst_ex_op", ex_op, '0);
        check("rst_stall_cnt", stall_cnt, '0);

        resetn = 1;
        id_valid = 0;
        step();

        // ALU forward from EX on port 1
        sel_id = 4'b0100; rs_id = 5'd3; rt_id = 5'd5;
        ex_wen = 1; ex_waddr = 5'd5; ex_wdata = 32'hDEADBEEF; ex_is_load = 0;
        rf_rdata = {32'h11, 32'h11};
        id_valid = 1; ex_ready = 1;
        step();
        check("alu_fwd_p1", ex_op[63:32], 32'hDEADBEEF);
        check("alu_fwd_p0", ex_op[31:0], 32'h11);
        check("alu_fwd_valid", ex_valid, 1'b1);

        // load-use stall, then MEM forward
        set_load_hazard();
        #1 check("ldu_id_ready", id_ready, 1'b0);
        step();
        check("ldu_bubble", ex_valid, 1'b0);
        check("ldu_stall_cnt", stall_cnt, 16'd1);
        ex_wen = 0; ex_is_load = 0;
        mem_wen = 1; mem_waddr = 5'd3; mem_data_ok = 1; mem_wdata = 32'h42;
        step();
        check("ldu_mem_fwd", ex_op[31:0], 32'h42);
        check("ldu_valid", ex_valid, 1'b1);

        // register zero: never forwarded, never a hazard
        mem_wen = 0; rs_id = '0;
        ex_wen = 1; ex_waddr = '0; ex_wdata = 32'hFFFF; ex_is_load = 1;
        #1 check("zero_id_ready", id_ready, 1'b1);
        step();
        check("zero_op", ex_op[31:0], 32'h0);
        check("zero_stall_cnt", stall_cnt, 16'd1);

        // backpressure holds, then flush
        ex_wen = 0; ex_is_load = 0; ex_ready = 0;
        held_op = ex_op;
        for (int i = 0; i < 3; i++) begin
            sel_id = 4'b0100; rs_id = 5'($urandom_range(1, 31)); rt_id = 5'($urandom_range(1, 31));
            rf_rdata = {$urandom, $urandom}; id_valid = 1;
            #1 check("bp_id_ready", id_ready, 1'b0);
            step();
            check("bp_hold", ex_op, held_op);
        end
        flush = 1;
        step();
        check("flush_valid", ex_valid, 1'b0);
        flush = 0;

        // flush beats hazard: counter untouched
        set_load_hazard();
        flush = 1;
        step();
        check("flush_haz_cnt", stall_cnt, 16'd1);
        flush = 0;

        // counter saturation on the narrow instance
        resetn = 0;
        step();
        resetn = 1;
        set_load_hazard();
        for (int i = 0; i < 10; i++) step();
        check("sat_cnt", s_stall_cnt, 3'd7);
        check("wide_cnt", stall_cnt, 16'd10);

        // reset in the middle of a stall restarts the counter
        resetn = 0;
        step();
        check("mid_rst_cnt", stall_cnt, '0);
        resetn = 1;
        step();
        check("post_rst_cnt", stall_cnt, 16'd1);

        // two ports on the same index see the same value
        clear_inputs();
        sel_id = 4'b0000; rs_id = 5'd4;
        ex_wen = 1; ex_waddr = 5'd4; ex_wdata = $urandom;
        rf_rdata = {32'hAAAA, 32'h5555}; id_valid = 1;
        step();
        check("same_idx", ex_op[63:32], ex_op[31:0]);
        check("same_idx_val", ex_op[31:0], ex_wdata);

        // random traffic with small index range for frequent hits
        for (int i = 0; i < 500; i++) begin
            resetn      = ($urandom_range(0, 49) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            ex_ready    = 1'($urandom);
            rs_id       = 5'($urandom_range(0, 3));
            rt_id       = 5'($urandom_range(0, 3));
            rd_id       = 5'($urandom_range(0, 3));
            sel_id      = 4'($urandom);
            rf_rdata    = {$urandom, $urandom};
            ex_wen      = 1'($urandom);
            ex_is_load  = ($urandom_range(0, 3) == 0);
            ex_waddr    = 5'($urandom_range(0, 3));
            ex_wdata    = $urandom;
            mem_wen     = 1'($urandom);
            mem_data_ok = ($urandom_range(0, 3) != 0);
            mem_waddr   = 5'($urandom_range(0, 3));
            mem_wdata   = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
